// File: rtl/core_fd_queue_if.sv
// Handshake bundle between fetch, the fetch/decode instruction queue and decode.
// The slave modport is the queue's view. The master modport is the surrounding core's view.
interface core_fd_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fd_istr;
  logic [31:0]   fd_pc;
  logic          fd_valid;
  logic          fd_jump;
  logic          fd_ready;
  logic          flush_en;
  logic          ctr_stop;
  logic [31:0]   id_istr;
  logic [31:0]   id_pc;
  logic          id_jump;
  logic          id_rvc;
  logic          id_valid;
  logic          id_ready;
  logic [CW-1:0] q_count;

  modport slave (
    input  fd_istr, fd_pc, fd_valid, fd_jump, flush_en, ctr_stop, id_ready,
    output fd_ready, id_istr, id_pc, id_jump, id_rvc, id_valid, q_count
  );

  modport master (
    output fd_istr, fd_pc, fd_valid, fd_jump, flush_en, ctr_stop, id_ready,
    input  fd_ready, id_istr, id_pc, id_jump, id_rvc, id_valid, q_count
  );
endinterface

// File: rtl/core_fd_queue.sv
// Fetch-to-decode instruction queue: a circular buffer of DEPTH entries with flush and a decode-issue freeze.
// There is no bypass, so a pushed entry becomes visible at the head on the following cycle.
module core_fd_queue #(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rest,
  core_fd_queue_if.slave        q_if
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   istr_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic          jump_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_s;
  logic          nonempty_s;
  logic          push_s;
  logic          pop_s;

  // Handshake qualifiers; fd_ready depends only on registered occupancy.
  always_comb begin
    full_s     = (count_q == CW'(DEPTH));
    nonempty_s = (count_q != CW'(0));
    push_s     = q_if.fd_valid & ~full_s & ~q_if.flush_en;
    pop_s      = nonempty_s & ~q_if.ctr_stop & q_if.id_ready & ~q_if.flush_en;
  end

  // Pointer and occupancy next-state; a flush overrides any push or pop in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q_if.flush_en) begin
      wr_ptr_d = AW'(0);
      rd_ptr_d = AW'(0);
      count_d  = CW'(0);
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; it is cleared on reset so that the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      for (int i = 0; i < DEPTH; i++) begin
        istr_q[i] <= 32'h0000_0000;
        pc_q[i]   <= 32'h0000_0000;
        jump_q[i] <= 1'b0;
      end
    end else if (push_s) begin
      istr_q[wr_ptr_q] <= q_if.fd_istr;
      pc_q[wr_ptr_q]   <= q_if.fd_pc;
      jump_q[wr_ptr_q] <= q_if.fd_jump;
    end
  end

  assign q_if.fd_ready = ~full_s;
  assign q_if.id_valid = nonempty_s & ~q_if.ctr_stop;
  assign q_if.id_istr  = istr_q[rd_ptr_q];
  assign q_if.id_pc    = pc_q[rd_ptr_q];
  assign q_if.id_jump  = jump_q[rd_ptr_q];
  assign q_if.id_rvc   = (istr_q[rd_ptr_q][1:0] != 2'b11);
  assign q_if.q_count  = count_q;
endmodule

// File: tb/tb_core_fd_queue.sv
// Scoreboard bench for core_fd_queue: stimulus records accepted instructions, and a negedge monitor checks the head, occupancy and handshakes.
module tb_core_fd_queue;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] istr;
    logic        jump;
  } ent_t;

  logic clk = 1'b0;
  logic rest = 1'b0;
  core_fd_queue_if #(.DEPTH(DEPTH)) q_if ();

  core_fd_queue #(.DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rest (rest),
    .q_if (q_if)
  );

  always #5 clk = ~clk;

  ent_t sb[$];
  ent_t pend_e;
  bit   pend_push = 1'b0;
  bit   mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares the DUT with the model state for this cycle, then retires the popped entry.
  always @(negedge clk) begin
    if (mon_en && rest) begin
      chk("q_count", 32'(q_if.q_count), 32'(sb.size()));
      chk("fd_ready", 32'(q_if.fd_ready), 32'(sb.size() != DEPTH));
      chk("id_valid", 32'(q_if.id_valid), 32'((sb.size() != 0) && !q_if.ctr_stop));
      if (sb.size() != 0) begin
        chk("id_pc", q_if.id_pc, sb[0].pc);
        chk("id_istr", q_if.id_istr, sb[0].istr);
        chk("id_jump", 32'(q_if.id_jump), 32'(sb[0].jump));
        chk("id_rvc", 32'(q_if.id_rvc), 32'(sb[0].istr[1:0] != 2'b11));
      end
      if (q_if.flush_en) sb.delete();
      else if (sb.size() != 0 && !q_if.ctr_stop && q_if.id_ready) void'(sb.pop_front());
    end
  end

  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] istr,
                     input logic j, input logic rdy, input logic fl, input logic st);
    @(posedge clk);
    #1;
    if (pend_push) sb.push_back(pend_e);
    pend_push = v && !fl && (sb.size() != DEPTH);
    pend_e = '{pc: pc, istr: istr, jump: j};
    q_if.fd_valid = v;
    q_if.fd_pc    = pc;
    q_if.fd_istr  = istr;
    q_if.fd_jump  = j;
    q_if.id_ready = rdy;
    q_if.flush_en = fl;
    q_if.ctr_stop = st;
  endtask

  task automatic push_until(input logic [31:0] pc, input logic [31:0] istr, input logic j,
                            input logic rdy, input logic st);
    int n = 0;
    do begin
      cyc(1'b1, pc, istr, j, rdy, 1'b0, st);
      n++;
    end while (!pend_push && n < 20);
    if (!pend_push) begin
      errors++;
      $display("FAIL push_timeout: pc %0h not accepted within %0d cycles", pc, n);
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, 1'b0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    q_if.fd_valid = 1'b0; q_if.fd_pc = 32'h0; q_if.fd_istr = 32'h0; q_if.fd_jump = 1'b0;
    q_if.id_ready = 1'b1; q_if.flush_en = 1'b0; q_if.ctr_stop = 1'b0;

    // Reset held low for five cycles.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_fd_ready", 32'(q_if.fd_ready), 32'd1);
      chk("rst_id_valid", 32'(q_if.id_valid), 32'd0);
      chk("rst_q_count", 32'(q_if.q_count), 32'd0);
      chk("rst_id_pc", q_if.id_pc, 32'h0);
    end
    chk("rst_id_rvc", 32'(q_if.id_rvc), 32'd1);
    #2 rest = 1'b1;
    mon_en = 1'b1;
    idle(2, 1'b1);

    // Streaming test.
    push_until(32'h0, 32'h0000_0013, 1'b0, 1'b1, 1'b0);
    push_until(32'h4, 32'h0000_4501, 1'b0, 1'b1, 1'b0);
    push_until(32'h6, 32'h00A0_0093, 1'b0, 1'b1, 1'b0);
    push_until(32'hA, 32'h0000_8082, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Fill, backpressure and wrap-around.
    for (int i = 0; i < 4; i++) push_until(32'h100 + 32'(4*i), 32'h13 + 32'(i << 7), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h110, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    push_until(32'h110, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
    push_until(32'h114, 32'h0000_0093, 1'b0, 1'b1, 1'b0);
    idle(6, 1'b1);

    // Flush test.
    for (int i = 0; i < 3; i++) push_until(32'h200 + 32'(4*i), 32'h0000_0013, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h40, 32'h0000_0013, 1'b0, 1'b1, 1'b1, 1'b0);
    push_until(32'h10, 32'h0000_4501, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Stop test.
    push_until(32'h300, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
    push_until(32'h304, 32'h0000_0093, 1'b0, 1'b0, 1'b0);
    push_until(32'h308, 32'h0000_4501, 1'b0, 1'b1, 1'b1);
    push_until(32'h30A, 32'h0000_0113, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 32'h30E, 32'h0000_0013, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(6, 1'b1);

    // Jump flag, followed by an asynchronous reset while the queue is nonempty.
    push_until(32'h60, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
    push_until(32'h64, 32'h0000_4501, 1'b1, 1'b0, 1'b0);
    push_until(32'h68, 32'h0000_0093, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b0);
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    rest = 1'b0;
    sb.delete();
    pend_push = 1'b0;
    q_if.fd_valid = 1'b0;
    #1;
    chk("arst_id_valid", 32'(q_if.id_valid), 32'd0);
    chk("arst_q_count", 32'(q_if.q_count), 32'd0);
    chk("arst_fd_ready", 32'(q_if.fd_ready), 32'd1);
    chk("arst_id_pc", q_if.id_pc, 32'h0);
    @(posedge clk);
    #3 rest = 1'b1;
    mon_en = 1'b1;
    push_until(32'h80, 32'h0000_0013, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 3) != 0),
          32'($urandom) & 32'hFFFF_FFFE,
          32'($urandom),
          1'($urandom_range(0, 1)),
          1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 29) == 0),
          1'($urandom_range(0, 9) == 0));
    end
    idle(8, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/core_fd_queue.md
# core_fd_queue

Instruction queue between the fetch stage (`core_if`) and the decode stage. It accepts fetched instructions through the `fd_*` valid/ready handshake and buffers up to `DEPTH` entries. It presents them in order to decode through an `id_*` valid/ready handshake. Fetch stalls are decoupled from decode stalls, the queue drains on a pipeline flush, and decode issue is frozen while the core is stopped.

## Interface
- `DEPTH`, 4: number of queue entries; power of two, minimum 2.
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rest`  in  1  asynchronous active-low reset.
- `fd_istr`  in  32  fetched instruction; for a compressed instruction only [15:0] is meaningful.
- `fd_pc`  in  32  PC of `fd_istr`.
- `fd_valid`  in  1  fetch presents an instruction.
- `fd_jump`  in  1  fetch predicted this instruction as taken; stored with the entry.
- `fd_ready`  out  1  queue can accept an instruction this cycle.
- `flush_en`  in  1  synchronous flush; discards all entries and the incoming instruction.
- `ctr_stop`  in  1  freeze decode issue.
- `id_istr`  out  32  head instruction.
- `id_pc`  out  32  head PC.
- `id_jump`  out  1  head predicted-taken flag.
- `id_rvc`  out  1  head is compressed: `id_istr[1:0] != 2'b11`.
- `id_valid`  out  1  head entry valid for decode.
- `id_ready`  in  1  decode accepts the head this cycle.
- `q_count`  out  log2(DEPTH)+1  current occupancy (debug/perf).

## Operation
- Storage: circular buffer of `DEPTH` entries {istr[31:0], pc[31:0], jump}, with `wr_ptr`/`rd_ptr` of log2(DEPTH) bits that wrap naturally, plus `count` of log2(DEPTH)+1 bits.
- `fd_ready = (count != DEPTH)`. It depends only on registered state, never on `id_ready` or `fd_valid`.
- Push: `push = fd_valid & fd_ready & ~flush_en`. It writes the entry at `wr_ptr` and increments `wr_ptr`.
- `id_valid = (count != 0) & ~ctr_stop`.
- `id_istr`/`id_pc`/`id_jump` = entry at `rd_ptr`, decoded combinationally from registers. They are undefined-but-stable when `count == 0`.
- Pop: `pop = id_valid & id_ready & ~flush_en`. It increments `rd_ptr`.
- Count update: `count` += push − pop. Simultaneous push and pop leaves `count` unchanged.
- `id_rvc` is derived from the head `id_istr[1:0]`.
- `ctr_stop`:
  - blocks pops only;
  - pushes continue until full;
  - head data is unchanged while stopped.
- Flush: in a cycle with `flush_en` = 1, the next edge sets `wr_ptr = rd_ptr = 0` and `count = 0`. Any push or pop in that cycle is ignored.
- No bypass: an instruction pushed into an empty queue becomes visible at the head the cycle after the push.

## Timing
- Reset (`rest` = 0, asynchronous):
  - pointers, `count` and all entry storage go to 0;
  - `fd_ready` = 1 immediately;
  - `id_valid` = 0;
  - `id_istr` = 0, `id_pc` = 0, `id_jump` = 0, `id_rvc` = 1 (istr[1:0] = 0).
- Reset asserted mid-operation discards all contents asynchronously. The first push is accepted on the first edge after `rest` rises.
- Latency: push at edge N makes `id_valid` = 1 during cycle N+1, provided `ctr_stop` = 0.
- Throughput: 1 instruction/cycle in and out in steady state.
- Full (`count == DEPTH`): `fd_ready` = 0 even if `id_ready` = 1 in the same cycle. `fd_ready` returns to 1 in the cycle after a pop.
- Empty: `id_valid` = 0 regardless of `id_ready`. `id_ready` may be high with no effect.
- Wrap-around: pointer increments from DEPTH−1 to 0 with ordering preserved.
- Flush: `id_valid` = 0 and `fd_ready` = 1 from the cycle after `flush_en` onward. Fetch's redirected instruction can be pushed in that cycle.
- Upstream contract: fetch holds `fd_istr`/`fd_pc`/`fd_jump` stable while `fd_valid & ~fd_ready`. The queue does not depend on this for correctness.

## Test plan
- Reset/empty: hold `rest` = 0 for 5 cycles, then release → `fd_ready` = 1, `id_valid` = 0, `q_count` = 0, `id_pc` = 0 throughout.
- Streaming:
  - stimulus: push PCs 0x0, 0x4, 0x6, 0xA with istr 0x00000013, 0x4501, 0x00A00093, 0x8082; `id_ready` = 1;
  - response: each emerges one cycle after its push, in order;
  - `id_rvc` pattern = 0, 1, 0, 1;
  - `q_count` never exceeds 1.
- Fill/backpressure/wrap:
  - stimulus: `id_ready` = 0 and push 6 instructions;
  - response: `fd_ready` drops after the 4th push and `q_count` = 4;
  - then: raise `id_ready`;
  - response: PCs appear 1st–4th in order, then the 5th and 6th after wrap; no loss or duplication.
- Flush:
  - stimulus: with 3 entries queued, pulse `flush_en` together with `fd_valid` (PC 0x40) and `id_ready` = 1;
  - response: next cycle `q_count` = 0, `id_valid` = 0, PC 0x40 is never presented;
  - then: push PC 0x10 the following cycle;
  - response: 0x10 emerges next.
- Stop:
  - stimulus: `ctr_stop` = 1 with 2 entries queued and `id_ready` = 1;
  - response: `id_valid` = 0 and the head stays at the first PC; pushes continue to `q_count` = 4;
  - then: drop `ctr_stop`;
  - response: draining resumes in order.
- Jump flag / async reset:
  - stimulus: push PC 0x64 with `fd_jump` = 1;
  - response: `id_jump` = 1 at the head only for that entry;
  - then: assert `rest` = 0 between clock edges while the queue is nonempty;
  - response: `id_valid` falls immediately and `q_count` = 0.
